// File: rtl/dcache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// dcache_ctrl_pkg : shared constants and state encoding for the data cache
// Rev 1.0
// ============================================================================
package dcache_ctrl_pkg;

    localparam int DCACHE_LINES      = 4;
    localparam int DCACHE_INDEX_W    = $clog2(DCACHE_LINES);
    localparam int DCACHE_WORD_W     = 32;
    localparam int DCACHE_ADDR_W     = 32;
    localparam int DCACHE_LINE_W     = 128;
    localparam int DCACHE_WORD_SEL_W = $clog2(DCACHE_LINE_W / DCACHE_WORD_W);

    typedef enum logic [1:0] {
        DC_IDLE      = 2'd0,
        DC_WRITEBACK = 2'd1,
        DC_FILL      = 2'd2,
        DC_RESPOND   = 2'd3
    } dc_state_t;

endpackage : dcache_ctrl_pkg
`default_nettype wire

// File: rtl/dcache_ctrl_if.sv
`default_nettype none
// ============================================================================
// dcache_ctrl_if : load/drain-write requester side plus line-wide memory side
// Rev 1.0
// ============================================================================
interface dcache_ctrl_if
    import dcache_ctrl_pkg::*;
#(
    parameter int ADDR_W = DCACHE_ADDR_W,
    parameter int WORD_W = DCACHE_WORD_W,
    parameter int LINE_W = DCACHE_LINE_W
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              wr_done;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;

    // The cache itself is the slave; pipeline, store buffer and memory together form the master.
    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_rdata, mem_ready,
        output rd_data, rd_valid, wr_done, stall, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_rdata, mem_ready,
        input  rd_data, rd_valid, wr_done, stall, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface : dcache_ctrl_if
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// ============================================================================
// dcache_array : tag/valid/dirty/data storage with combinational lookup
// Rev 1.0
// ============================================================================
module dcache_array #(
    parameter int LINES   = 4,
    parameter int WORD_W  = 32,
    parameter int LINE_W  = 128,
    parameter int TAG_W   = 26,
    parameter int INDEX_W = $clog2(LINES),
    parameter int WSEL_W  = $clog2(LINE_W / WORD_W)
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic [INDEX_W-1:0] index,
    input  wire logic [TAG_W-1:0]   tag,
    output logic                    hit,
    output logic                    victim_dirty,
    output logic [TAG_W-1:0]        victim_tag,
    output logic [LINE_W-1:0]       line_out,
    input  wire logic               word_we,
    input  wire logic [WSEL_W-1:0]  word_sel,
    input  wire logic [WORD_W-1:0]  word_data,
    input  wire logic               install,
    input  wire logic [LINE_W-1:0]  install_line,
    input  wire logic               clr_dirty
);

    logic [LINE_W-1:0] r_data [LINES];
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [LINES-1:0]  r_valid;
    logic [LINES-1:0]  r_dirty;

    assign hit          = r_valid[index] && (r_tag[index] == tag);
    assign victim_dirty = r_valid[index] && r_dirty[index];
    assign victim_tag   = r_tag[index];
    assign line_out     = r_data[index];

    // Payload storage carries no reset; only the valid/dirty bits gate its use.
    always_ff @(posedge clk) begin
        if (install) begin
            r_data[index] <= install_line;
            r_tag[index]  <= tag;
        end else if (word_we) begin
            r_data[index][word_sel*WORD_W +: WORD_W] <= word_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (install) begin
            r_valid[index] <= 1'b1;
            r_dirty[index] <= 1'b0;
        end else if (word_we) begin
            r_dirty[index] <= 1'b1;
        end else if (clr_dirty) begin
            r_dirty[index] <= 1'b0;
        end
    end

endmodule : dcache_array
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// dcache_ctrl : direct-mapped write-back write-allocate data cache controller
// Rev 1.0
// ============================================================================
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int LINES  = DCACHE_LINES,
    parameter int WORD_W = DCACHE_WORD_W,
    parameter int ADDR_W = DCACHE_ADDR_W,
    parameter int LINE_W = DCACHE_LINE_W
) (
    input  wire logic    clk,
    input  wire logic    rst,
    dcache_ctrl_if.slave bus
);

    localparam int INDEX_W = $clog2(LINES);
    localparam int WSEL_W  = $clog2(LINE_W / WORD_W);
    localparam int BYTE_W  = $clog2(WORD_W / 8);
    localparam int OFF_W   = $clog2(LINE_W / 8);
    localparam int TAG_W   = ADDR_W - OFF_W - INDEX_W;

    dc_state_t         r_state;
    logic              r_is_rd;
    logic [WORD_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_wr_done;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [LINE_W-1:0] r_mem_wdata;

    logic              w_sel_rd;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_line_addr;
    logic [INDEX_W-1:0] w_index;
    logic [TAG_W-1:0]  w_tag;
    logic [WSEL_W-1:0] w_wsel;
    logic [WORD_W-1:0] w_word;
    logic              w_hit;
    logic              w_victim_dirty;
    logic [TAG_W-1:0]  w_victim_tag;
    logic [LINE_W-1:0] w_line;
    logic              w_word_we;
    logic              w_install;
    logic              w_clr_dirty;
    logic              w_unused_byte;

    // Arbitration picks the read in IDLE; afterwards the latched choice keeps the address steady.
    assign w_sel_rd      = (r_state == DC_IDLE) ? bus.rd_req : r_is_rd;
    assign w_addr        = w_sel_rd ? bus.rd_addr : bus.wr_addr;
    assign w_line_addr   = {w_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign w_index       = w_addr[OFF_W +: INDEX_W];
    assign w_tag         = w_addr[ADDR_W-1 -: TAG_W];
    assign w_wsel        = w_addr[BYTE_W +: WSEL_W];
    assign w_word        = w_line[w_wsel*WORD_W +: WORD_W];
    assign w_unused_byte = ^w_addr[BYTE_W-1:0];

    assign w_word_we   = (r_state == DC_IDLE) && !bus.rd_req && bus.wr_req && w_hit;
    assign w_install   = (r_state == DC_FILL) && r_mem_req && bus.mem_ready;
    assign w_clr_dirty = (r_state == DC_WRITEBACK) && bus.mem_ready;

    dcache_array #(
        .LINES   (LINES),
        .WORD_W  (WORD_W),
        .LINE_W  (LINE_W),
        .TAG_W   (TAG_W),
        .INDEX_W (INDEX_W),
        .WSEL_W  (WSEL_W)
    ) u_array (
        .clk          (clk),
        .rst          (rst),
        .index        (w_index),
        .tag          (w_tag),
        .hit          (w_hit),
        .victim_dirty (w_victim_dirty),
        .victim_tag   (w_victim_tag),
        .line_out     (w_line),
        .word_we      (w_word_we),
        .word_sel     (w_wsel),
        .word_data    (bus.wr_data),
        .install      (w_install),
        .install_line (bus.mem_rdata),
        .clr_dirty    (w_clr_dirty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= DC_IDLE;
            r_is_rd     <= 1'b0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_wr_done   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                DC_IDLE: begin
                    if (bus.rd_req || bus.wr_req) begin
                        r_is_rd <= bus.rd_req;
                        if (w_hit) begin
                            r_state    <= DC_RESPOND;
                            r_rd_valid <= bus.rd_req;
                            r_wr_done  <= !bus.rd_req;
                            if (bus.rd_req) begin
                                r_rd_data <= w_word;
                            end
                        end else if (w_victim_dirty) begin
                            r_state     <= DC_WRITEBACK;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= {w_victim_tag, w_index, {OFF_W{1'b0}}};
                            r_mem_wdata <= w_line;
                        end else begin
                            r_state    <= DC_FILL;
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= w_line_addr;
                        end
                    end
                end
                DC_WRITEBACK: begin
                    // Drop the request for one cycle so each memory transaction has a clean start.
                    if (bus.mem_ready) begin
                        r_state    <= DC_FILL;
                        r_mem_req  <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= w_line_addr;
                    end
                end
                DC_FILL: begin
                    if (w_install) begin
                        r_state   <= DC_IDLE;
                        r_mem_req <= 1'b0;
                    end else begin
                        r_mem_req <= 1'b1;
                    end
                end
                DC_RESPOND: begin
                    r_state    <= DC_IDLE;
                    r_rd_valid <= 1'b0;
                    r_wr_done  <= 1'b0;
                end
                default: begin
                    r_state <= DC_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_data   = r_rd_data;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.wr_done   = r_wr_done;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.stall     = rst && bus.rd_req && !r_rd_valid;

endmodule : dcache_ctrl
`default_nettype wire
